// File: rtl/tap_pkg.sv
// Shared TAP tape constants and state encoding, used by the recorder and the player.
package tap_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEEK,
        ST_PILOT,
        ST_SYNC2,
        ST_BIT_A,
        ST_BIT_B,
        ST_LEN_LO,
        ST_LEN_HI
    } tap_state_e;

    // Real-time constants for a 3.5 MHz clock
    localparam int unsigned TAP_PILOT_MIN   = 1900;
    localparam int unsigned TAP_SYNC_MAX    = 1100;
    localparam int unsigned TAP_BIT_SPLIT   = 2565;
    localparam int unsigned TAP_PILOT_COUNT = 256;
    localparam int unsigned TAP_TIMEOUT     = 65535;

    // Scaled set (about 1/10 of the real timing) for fast simulation
    localparam int unsigned TAP_ICARUS_PILOT_MIN   = 190;
    localparam int unsigned TAP_ICARUS_SYNC_MAX    = 110;
    localparam int unsigned TAP_ICARUS_BIT_SPLIT   = 256;
    localparam int unsigned TAP_ICARUS_PILOT_COUNT = 16;
    localparam int unsigned TAP_ICARUS_TIMEOUT     = 1000;

    // A bit is 1 when its two half-periods together reach the split width
    function automatic logic tap_bit(input logic [16:0] sum, input int unsigned split);
        return ({15'd0, sum} >= 32'(split));
    endfunction

endpackage

// File: rtl/tap_edge.sv
// EAR synchroniser, edge detector and saturating half-period width counter.
module tap_edge
    import tap_pkg::*;
#(
    parameter int unsigned TIMEOUT = TAP_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        i_en,
    input  logic        i_ear,
    output logic        o_edge,
    output logic [15:0] o_width,
    output logic        o_timeout
);

    localparam logic [15:0] L_LIM = 16'(TIMEOUT);

    logic        r_s1;
    logic        r_s2;
    logic        r_lvl;
    logic [15:0] r_cnt;
    logic        w_edge;

    // Free-running two-flop synchroniser so an edge seen during hold is kept
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
        end else begin
            r_s1 <= i_ear;
            r_s2 <= r_s1;
        end
    end

    assign w_edge = i_en && (r_s2 != r_lvl);

    // Track the processed level and count enabled cycles since the last edge
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lvl <= 1'b1;
            r_cnt <= '0;
        end else if (i_en) begin
            if (w_edge) begin
                r_lvl <= r_s2;
                r_cnt <= 16'd1;
            end else if (r_cnt < L_LIM) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign o_edge    = w_edge;
    assign o_width   = r_cnt;
    // Single pulse on the cycle the counter reaches its saturation value
    assign o_timeout = i_en && !w_edge && (r_cnt == L_LIM - 16'd1);

endmodule

// File: rtl/tap_rec.sv
// TAP recorder: decodes pilot/sync/data from EAR and writes length-prefixed blocks.
module tap_rec
    import tap_pkg::*;
#(
    parameter int unsigned PILOT_MIN   = TAP_PILOT_MIN,
    parameter int unsigned SYNC_MAX    = TAP_SYNC_MAX,
    parameter int unsigned BIT_SPLIT   = TAP_BIT_SPLIT,
    parameter int unsigned PILOT_COUNT = TAP_PILOT_COUNT,
    parameter int unsigned TIMEOUT     = TAP_TIMEOUT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        hold_n,
    input  logic        record,
    input  logic        ear,
    output logic [16:0] tap_address,
    output logic [7:0]  tap_wdata,
    output logic        tap_we,
    output logic [7:0]  blocks,
    output logic        overflow
);

    localparam logic [15:0] L_PMIN = 16'(PILOT_MIN);
    localparam logic [15:0] L_SMAX = 16'(SYNC_MAX);
    localparam logic [15:0] L_PCNT = 16'(PILOT_COUNT);

    tap_state_e  r_state;
    logic [16:0] r_addr;
    logic [7:0]  r_wdata;
    logic        r_we;
    logic [7:0]  r_blocks;
    logic        r_ovf;
    logic [16:0] r_blk_start;
    logic [16:0] r_ptr;
    logic [15:0] r_len;
    logic [15:0] r_pilot;
    logic [15:0] r_wa;
    logic [7:0]  r_byte;
    logic [2:0]  r_bit;
    logic        r_hi_done;

    logic        w_en;
    logic        w_edge;
    logic [15:0] w_width;
    logic        w_timeout;
    logic [16:0] w_sum;
    logic [7:0]  w_byte;
    logic        w_active;
    logic        w_blk_end;
    tap_state_e  w_after;

    assign w_en = ~hold_n;

    tap_edge #(.TIMEOUT(TIMEOUT)) u_edge (
        .clock     (clock),
        .reset     (reset),
        .i_en      (w_en),
        .i_ear     (ear),
        .o_edge    (w_edge),
        .o_width   (w_width),
        .o_timeout (w_timeout)
    );

    assign w_sum     = {1'b0, r_wa} + {1'b0, w_width};
    assign w_byte    = {r_byte[6:0], tap_bit(w_sum, BIT_SPLIT)};
    assign w_active  = (r_state == ST_PILOT) || (r_state == ST_SYNC2) ||
                       (r_state == ST_BIT_A) || (r_state == ST_BIT_B);
    assign w_blk_end = w_active && (w_timeout || !record);
    assign w_after   = (record && !r_ovf) ? ST_SEEK : ST_IDLE;

    // Recorder FSM; strobe clears every cycle so hold cannot stretch a write
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_we        <= 1'b0;
            r_blocks    <= '0;
            r_ovf       <= 1'b0;
            r_blk_start <= '0;
            r_ptr       <= '0;
            r_len       <= '0;
            r_pilot     <= '0;
            r_wa        <= '0;
            r_byte      <= '0;
            r_bit       <= '0;
            r_hi_done   <= 1'b0;
        end else begin
            r_we <= 1'b0;
            if (w_en) begin
                if (w_blk_end) begin
                    // Partial byte is dropped; only whole bytes count toward len
                    if (r_len != '0) begin
                        r_state <= ST_LEN_LO;
                    end else begin
                        r_addr  <= r_blk_start;
                        r_ptr   <= r_blk_start + 17'd2;
                        r_pilot <= '0;
                        r_state <= w_after;
                    end
                end else begin
                    case (r_state)
                        ST_IDLE: begin
                            if (record && !r_ovf) begin
                                r_blk_start <= r_addr;
                                r_ptr       <= r_addr + 17'd2;
                                r_len       <= '0;
                                r_pilot     <= '0;
                                r_state     <= ST_SEEK;
                            end
                        end
                        ST_SEEK, ST_PILOT: begin
                            if (r_state == ST_SEEK && !record) begin
                                r_state <= ST_IDLE;
                            end else if (r_state == ST_SEEK && w_timeout) begin
                                r_pilot <= '0;
                            end else if (w_edge) begin
                                if (w_width >= L_PMIN) begin
                                    if (r_pilot != '1)
                                        r_pilot <= r_pilot + 16'd1;
                                    r_state <= ST_PILOT;
                                end else if (w_width <= L_SMAX && r_pilot >= L_PCNT) begin
                                    r_pilot <= '0;
                                    r_state <= ST_SYNC2;
                                end else begin
                                    r_pilot <= '0;
                                    r_state <= ST_SEEK;
                                end
                            end
                        end
                        ST_SYNC2: begin
                            if (w_edge) begin
                                if (w_width <= L_SMAX) begin
                                    r_bit   <= 3'd7;
                                    r_byte  <= '0;
                                    r_state <= ST_BIT_A;
                                end else begin
                                    r_state <= ST_SEEK;
                                end
                            end
                        end
                        ST_BIT_A: begin
                            if (w_edge) begin
                                r_wa    <= w_width;
                                r_state <= ST_BIT_B;
                            end
                        end
                        ST_BIT_B: begin
                            if (w_edge) begin
                                r_byte <= w_byte;
                                if (r_bit == 3'd0) begin
                                    r_we    <= 1'b1;
                                    r_addr  <= r_ptr;
                                    r_wdata <= w_byte;
                                    r_ptr   <= r_ptr + 17'd1;
                                    r_len   <= r_len + 16'd1;
                                    if (r_ptr == '1) begin
                                        r_ovf   <= 1'b1;
                                        r_state <= ST_LEN_LO;
                                    end else begin
                                        r_bit   <= 3'd7;
                                        r_state <= ST_BIT_A;
                                    end
                                end else begin
                                    r_bit   <= r_bit - 3'd1;
                                    r_state <= ST_BIT_A;
                                end
                            end
                        end
                        ST_LEN_LO: begin
                            // Waits one cycle if a data write just went out
                            if (!r_we) begin
                                r_we      <= 1'b1;
                                r_addr    <= r_blk_start;
                                r_wdata   <= r_len[7:0];
                                r_hi_done <= 1'b0;
                                r_state   <= ST_LEN_HI;
                            end
                        end
                        ST_LEN_HI: begin
                            if (r_hi_done) begin
                                r_addr      <= r_ptr;
                                r_blocks    <= r_blocks + 8'd1;
                                r_blk_start <= r_ptr;
                                r_ptr       <= r_ptr + 17'd2;
                                r_len       <= '0;
                                r_pilot     <= '0;
                                r_state     <= w_after;
                            end else if (!r_we) begin
                                r_we      <= 1'b1;
                                r_addr    <= r_blk_start + 17'd1;
                                r_wdata   <= r_len[15:8];
                                r_hi_done <= 1'b1;
                            end
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign tap_address = r_addr;
    assign tap_wdata   = r_wdata;
    assign tap_we      = r_we;
    assign blocks      = r_blocks;
    assign overflow    = r_ovf;

endmodule

// File: tb/tb_tap_rec.sv
// Directed bench for tap_rec using the scaled timing set.
module tb_tap_rec;
    import tap_pkg::*;

    localparam int unsigned T_PILOT = 217;
    localparam int unsigned T_S1    = 67;
    localparam int unsigned T_S2    = 74;
    localparam int unsigned T_ZERO  = 86;
    localparam int unsigned T_ONE   = 171;
    localparam int unsigned T_SIL   = 1200;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        hold_n = 1'b0;
    logic        record = 1'b0;
    logic        ear = 1'b1;
    logic [16:0] tap_address;
    logic [7:0]  tap_wdata;
    logic        tap_we;
    logic [7:0]  blocks;
    logic        overflow;

    int n_assert = 0;
    int n_fail   = 0;

    logic [24:0] wq[$];
    logic        prev_we = 1'b0;

    tap_rec #(
        .PILOT_MIN   (TAP_ICARUS_PILOT_MIN),
        .SYNC_MAX    (TAP_ICARUS_SYNC_MAX),
        .BIT_SPLIT   (TAP_ICARUS_BIT_SPLIT),
        .PILOT_COUNT (TAP_ICARUS_PILOT_COUNT),
        .TIMEOUT     (TAP_ICARUS_TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .hold_n      (hold_n),
        .record      (record),
        .ear         (ear),
        .tap_address (tap_address),
        .tap_wdata   (tap_wdata),
        .tap_we      (tap_we),
        .blocks      (blocks),
        .overflow    (overflow)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Capture every write and flag back-to-back strobes
    always @(negedge clock) begin
        if (tap_we) begin
            wq.push_back({tap_address, tap_wdata});
            check("we_not_consecutive", {31'd0, prev_we}, 32'd0);
        end
        prev_we = tap_we;
    end

    function automatic logic [31:0] q_get(input int i);
        if (i < wq.size()) return {7'd0, wq[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic wait_en(input int unsigned n);
        repeat (n) @(negedge clock);
    endtask

    // Close a half-period of length len with an edge; optionally freeze right after
    task automatic half(input int unsigned len, input bit do_hold);
        wait_en(len);
        ear = ~ear;
        if (do_hold) begin
            hold_n = 1'b1;
            repeat (1000) @(negedge clock);
            hold_n = 1'b0;
        end
    endtask

    task automatic pilot(input int unsigned n);
        repeat (n) half(T_PILOT, 1'b0);
        half(T_S1, 1'b0);
        half(T_S2, 1'b0);
    endtask

    task automatic send_byte(input logic [7:0] b, input int hold_at);
        int unsigned len;
        for (int i = 7; i >= 0; i--) begin
            len = b[i] ? T_ONE : T_ZERO;
            half(len, (hold_at == 2 * (7 - i)));
            half(len, (hold_at == 2 * (7 - i) + 1));
        end
    endtask

    task automatic do_reset();
        record = 1'b0;
        hold_n = 1'b0;
        reset  = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        wq.delete();
    endtask

    initial begin
        bit seen;

        // Reset state
        repeat (2) @(negedge clock);
        check("rst_addr", {15'd0, tap_address}, 32'd0);
        check("rst_wdata", {24'd0, tap_wdata}, 32'd0);
        check("rst_we", {31'd0, tap_we}, 32'd0);
        check("rst_blocks", {24'd0, blocks}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_state", 32'(dut.r_state), 32'(ST_IDLE));
        do_reset();

        // Block 1: 0x00, 0xFF
        record = 1'b1;
        wait_en(5);
        pilot(20);
        send_byte(8'h00, -1);
        send_byte(8'hFF, -1);
        wait_en(T_SIL);
        check("b1_nwr", wq.size(), 32'd4);
        check("b1_w0", q_get(0), {15'd0, 17'd2, 8'h00});
        check("b1_w1", q_get(1), {15'd0, 17'd3, 8'hFF});
        check("b1_w2", q_get(2), {15'd0, 17'd0, 8'h02});
        check("b1_w3", q_get(3), {15'd0, 17'd1, 8'h00});
        check("b1_blocks", {24'd0, blocks}, 32'd1);
        check("b1_addr", {15'd0, tap_address}, 32'd4);

        // Block 2 follows directly
        wq.delete();
        pilot(20);
        send_byte(8'h00, -1);
        send_byte(8'hFF, -1);
        wait_en(T_SIL);
        check("b2_nwr", wq.size(), 32'd4);
        check("b2_w0", q_get(0), {15'd0, 17'd6, 8'h00});
        check("b2_w1", q_get(1), {15'd0, 17'd7, 8'hFF});
        check("b2_w2", q_get(2), {15'd0, 17'd4, 8'h02});
        check("b2_w3", q_get(3), {15'd0, 17'd5, 8'h00});
        check("b2_blocks", {24'd0, blocks}, 32'd2);
        check("b2_addr", {15'd0, tap_address}, 32'd8);

        // Short pilot: sync is not accepted
        do_reset();
        record = 1'b1;
        wait_en(5);
        pilot(10);
        send_byte(8'h00, -1);
        send_byte(8'hFF, -1);
        wait_en(T_SIL);
        check("sp_nwr", wq.size(), 32'd0);
        check("sp_addr", {15'd0, tap_address}, 32'd0);
        check("sp_blocks", {24'd0, blocks}, 32'd0);

        // Five bits then silence: partial byte discarded
        do_reset();
        record = 1'b1;
        wait_en(5);
        pilot(20);
        repeat (10) half(T_ZERO, 1'b0);
        wait_en(T_SIL);
        check("pb_nwr", wq.size(), 32'd0);
        check("pb_blocks", {24'd0, blocks}, 32'd0);
        check("pb_addr", {15'd0, tap_address}, 32'd0);
        check("pb_state", 32'(dut.r_state), 32'(ST_SEEK));

        // Hold spanning an edge inside 0xA5
        do_reset();
        record = 1'b1;
        wait_en(5);
        pilot(20);
        send_byte(8'hA5, 3);
        wait_en(T_SIL);
        check("hd_nwr", wq.size(), 32'd3);
        check("hd_w0", q_get(0), {15'd0, 17'd2, 8'hA5});
        check("hd_w1", q_get(1), {15'd0, 17'd0, 8'h01});
        check("hd_w2", q_get(2), {15'd0, 17'd1, 8'h00});
        check("hd_blocks", {24'd0, blocks}, 32'd1);
        check("hd_addr", {15'd0, tap_address}, 32'd3);

        // Asynchronous reset landing on a data write strobe
        do_reset();
        record = 1'b1;
        wait_en(5);
        pilot(20);
        send_byte(8'h3C, -1);
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clock);
            if (tap_we) seen = 1'b1;
        end
        check("mr_we_seen", {31'd0, seen}, 32'd1);
        check("mr_pre_addr", {15'd0, tap_address}, 32'd2);
        check("mr_pre_data", {24'd0, tap_wdata}, 32'h3C);
        reset = 1'b1;
        #1;
        check("mr_we", {31'd0, tap_we}, 32'd0);
        check("mr_addr", {15'd0, tap_address}, 32'd0);
        check("mr_state", 32'(dut.r_state), 32'(ST_IDLE));
        check("mr_blocks", {24'd0, blocks}, 32'd0);
        @(negedge clock);
        reset  = 1'b0;
        record = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
